fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT_CYCLES, default 16, number of unacknowledged request cycles before the fetch error is raised.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset_L, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port StartPC, input, 64 bits: first fetch address after reset release.
REQ-005 The block SHALL have port BusImm, input, 64 bits: extended immediate from the sign extender for the held instruction.
REQ-006 The block SHALL have ports Branch, Uncondbranch and Zero, input, 1 bit each: conditional-branch flag, unconditional-branch flag and ALU zero flag for the held instruction.
REQ-007 The block SHALL have port Stall, input, 1 bit: consumer not ready; hold the current instruction.
REQ-008 The block SHALL have ports IMemReq (output, 1 bit), IMemAddr (output, 64 bits), IMemAck (input, 1 bit) and IMemData (input, 32 bits): the instruction memory request/acknowledge handshake.
REQ-009 The block SHALL have ports Instr (32 bits), InstrPC (64 bits) and InstrValid (1 bit), all outputs: the registered instruction word, its address and its valid flag.
REQ-010 The block SHALL have ports CurrentPC (output, 64 bits), the PC register, and FetchErr (output, 1 bit), a sticky timeout flag.

Function
REQ-011 FSM states SHALL be INIT, REQ, VALID and ERR.
REQ-012 INIT: on the first CLK edge after reset release, the block SHALL set PC=StartPC and move to REQ.
REQ-013 REQ: IMemReq=1 and IMemAddr=PC, both held stable until IMemAck=1.
REQ-014 REQ with IMemAck=1: on that edge the block SHALL capture Instr=IMemData and InstrPC=PC, set InstrValid=1 and move to VALID; InstrValid rises one cycle after the ack.
REQ-015 In VALID, IMemReq SHALL be 0, and Instr, InstrPC and InstrValid SHALL stay stable while Stall=1.
REQ-016 VALID with Stall=0: the block SHALL compute taken = Uncondbranch OR (Branch AND Zero), sampling BusImm, Branch, Uncondbranch and Zero in that cycle.
REQ-017 On that same edge it SHALL load PC = taken ? PC + (BusImm<<2) : PC + 4, clear InstrValid and move to REQ.
REQ-018 PC arithmetic SHALL be 64-bit modulo 2^64: wrap-around is silent, and BusImm<<2 discards BusImm[63:62].
REQ-019 Minimum throughput SHALL be one instruction per 2 cycles (ack in the first REQ cycle, Stall=0 in VALID).
REQ-020 A wait counter SHALL clear on entering REQ and increment for each REQ cycle without ack; on reaching TIMEOUT_CYCLES the block SHALL move to ERR.
REQ-021 ERR: FetchErr=1, IMemReq=0, InstrValid=0; ERR is left only by reset.
REQ-022 IMemAck SHALL be ignored in INIT, VALID and ERR.
REQ-023 An ack arriving on the same edge as the count reaching the limit SHALL be accepted (REQ -> VALID).
REQ-024 CurrentPC SHALL always equal the PC register.

Reset
REQ-025 While Reset_L=0, the block SHALL immediately force state=INIT, PC=0, Instr=0, InstrPC=0, InstrValid=0, IMemReq=0, IMemAddr=0, FetchErr=0 and the wait counter to 0.
REQ-026 Reset asserted mid-request SHALL drop IMemReq at once and abandon the pending transaction; a late ack after release SHALL be ignored.
REQ-027 StartPC SHALL be sampled only in INIT, never asynchronously.

Structure
REQ-028 The FSM state encodings, the PC increment constant (4) and the branch shift amount (2) SHALL live in the shared processor defines package, alongside the sign-extender control codes.
REQ-029 The block SHALL have one combinational sub-module, next_pc, with inputs PC, BusImm and taken and output NextPC; the FSM and registers stay in fetch_pc_unit.

Verification
REQ-030 StartPC=0x1000, release reset, ack after 3 REQ cycles with IMemData=0x8B020020 -> IMemAddr=0x1000 throughout; InstrValid=1 next cycle; Instr=0x8B020020; InstrPC=0x1000.
REQ-031 VALID at PC 0x1000, Stall=0, Branch=Uncondbranch=0 -> next IMemAddr=0x1004.
REQ-032 PC 0x1008, Uncondbranch=1, BusImm=0xFFFFFFFFFFFFFFFE -> next IMemAddr=0x1000.
REQ-033 PC 0x1008, Branch=1, Zero=0, BusImm=3 -> 0x100C; repeat with Zero=1 -> 0x1014.
REQ-034 PC 0xFFFFFFFFFFFFFFFC, no branch -> 0x0; Stall=1 for 5 cycles in VALID -> Instr and InstrPC unchanged and IMemReq=0 throughout.
REQ-035 No ack for 16 cycles -> FetchErr=1 and IMemReq=0 sticky; Reset_L low mid-REQ -> IMemReq=0 before the next edge and restart from StartPC.

Source files
------------

// File: rtl/fetch_pc_unit_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit_pkg : shared processor defines (fetch FSM, PC step, sign-ext codes)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pc_unit_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_t;

    localparam logic [63:0] PC_INCR  = 64'd4;
    localparam int          BR_SHIFT = 2;

    typedef enum logic [2:0] {
        SE_I  = 3'd0,
        SE_D  = 3'd1,
        SE_B  = 3'd2,
        SE_CB = 3'd3,
        SE_IW = 3'd4
    } sext_ctl_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_unit_next_pc.sv
// ---------------------------------------------------------------------------
// next_pc : sequential or branch-target PC selection, modulo 2^64
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module next_pc
    import fetch_pc_unit_pkg::*;
(
    input  logic [63:0] PC,
    input  logic [63:0] BusImm,
    input  logic        taken,
    output logic [63:0] NextPC
);

    // The shift drops BusImm[63:62]; the sum wraps silently.
    assign NextPC = taken ? (PC + (BusImm << BR_SHIFT)) : (PC + PC_INCR);

endmodule

`default_nettype wire

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit : PC register and instruction-fetch handshake FSM with timeout
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        CLK,
    input  logic        Reset_L,
    input  logic [63:0] StartPC,
    input  logic [63:0] BusImm,
    input  logic        Branch,
    input  logic        Uncondbranch,
    input  logic        Zero,
    input  logic        Stall,
    output logic        IMemReq,
    output logic [63:0] IMemAddr,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr,
    output logic [63:0] InstrPC,
    output logic        InstrValid,
    output logic [63:0] CurrentPC,
    output logic        FetchErr
);

    localparam int                CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [63:0]       pc;
    logic [63:0]       pc_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              load_start;
    logic              take_instr;
    logic              advance;
    logic              taken;

    assign taken = Uncondbranch | (Branch & Zero);

    next_pc u_next_pc (
        .PC     (pc),
        .BusImm (BusImm),
        .taken  (taken),
        .NextPC (pc_nxt)
    );

    // Ack has priority over the timeout, so an ack on the limit cycle is accepted.
    always_comb begin
        state_nxt  = state;
        load_start = 1'b0;
        take_instr = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_INIT: begin
                state_nxt  = ST_REQ;
                load_start = 1'b1;
            end
            ST_REQ: begin
                if (IMemAck) begin
                    state_nxt  = ST_VALID;
                    take_instr = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_VALID: begin
                if (!Stall) begin
                    state_nxt = ST_REQ;
                    advance   = 1'b1;
                end
            end
            ST_ERR:  state_nxt = ST_ERR;
            default: state_nxt = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state      <= ST_INIT;
            pc         <= 64'd0;
            Instr      <= 32'd0;
            InstrPC    <= 64'd0;
            InstrValid <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (load_start) begin
                pc <= StartPC;
            end else if (advance) begin
                pc <= pc_nxt;
            end
            if (take_instr) begin
                Instr      <= IMemData;
                InstrPC    <= pc;
                InstrValid <= 1'b1;
            end else if (advance) begin
                InstrValid <= 1'b0;
            end
            if (state_nxt == ST_REQ && state != ST_REQ) begin
                wait_cnt <= '0;
            end else if (state == ST_REQ && !IMemAck) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    assign IMemReq   = (state == ST_REQ);
    assign IMemAddr  = pc;
    assign CurrentPC = pc;
    assign FetchErr  = (state == ST_ERR);

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit : randomized transaction-level bench for fetch_pc_unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_pc_unit;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic [63:0] StartPC = 64'd0;
    logic [63:0] BusImm = 64'd0;
    logic        Branch = 1'b0;
    logic        Uncondbranch = 1'b0;
    logic        Zero = 1'b0;
    logic        Stall = 1'b0;
    logic        IMemReq;
    logic [63:0] IMemAddr;
    logic        IMemAck = 1'b0;
    logic [31:0] IMemData = 32'd0;
    logic [31:0] Instr;
    logic [63:0] InstrPC;
    logic        InstrValid;
    logic [63:0] CurrentPC;
    logic        FetchErr;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [63:0] m_pc;

    fetch_pc_unit #(.TIMEOUT_CYCLES(16)) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .StartPC      (StartPC),
        .BusImm       (BusImm),
        .Branch       (Branch),
        .Uncondbranch (Uncondbranch),
        .Zero         (Zero),
        .Stall        (Stall),
        .IMemReq      (IMemReq),
        .IMemAddr     (IMemAddr),
        .IMemAck      (IMemAck),
        .IMemData     (IMemData),
        .Instr        (Instr),
        .InstrPC      (InstrPC),
        .InstrValid   (InstrValid),
        .CurrentPC    (CurrentPC),
        .FetchErr     (FetchErr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input logic [63:0] sp, input logic late_ack);
        Reset_L = 1'b0;
        IMemAck = late_ack;
        IMemData = $urandom;
        #1;
        check("rst_req",   IMemReq,    1'b0);
        check("rst_addr",  IMemAddr,   64'd0);
        check("rst_valid", InstrValid, 1'b0);
        check("rst_instr", Instr,      32'd0);
        check("rst_ipc",   InstrPC,    64'd0);
        check("rst_err",   FetchErr,   1'b0);
        check("rst_pc",    CurrentPC,  64'd0);
        tick();
        tick();
        StartPC = sp;
        Reset_L = 1'b1;
        tick();
        IMemAck = 1'b0;
        StartPC = {$urandom, $urandom};
        m_pc = sp;
        check("init_pc",    CurrentPC,  sp);
        check("init_valid", InstrValid, 1'b0);
    endtask

    // One instruction: wait `delay` unacked REQ cycles, ack, stall, then release.
    task automatic do_instr(input int delay, input logic [31:0] data, input int stall,
                            input logic br, input logic ub, input logic z,
                            input logic [63:0] imm);
        int w;
        w = 0;
        while (IMemReq !== 1'b1 && w < 4) begin
            tick();
            w++;
        end
        check("req_seen", IMemReq, 1'b1);
        check("req_addr", IMemAddr, m_pc);
        for (int i = 0; i < delay; i++) begin
            IMemAck = 1'b0;
            IMemData = $urandom;
            Stall = 1'($urandom);
            tick();
            check("req_hold", IMemReq, 1'b1);
            check("addr_hold", IMemAddr, m_pc);
        end
        IMemAck = 1'b1;
        IMemData = data;
        tick();
        IMemAck = 1'b0;
        check("valid_set", InstrValid, 1'b1);
        check("instr", Instr, data);
        check("instr_pc", InstrPC, m_pc);
        check("valid_noreq", IMemReq, 1'b0);
        Stall = 1'b1;
        for (int k = 0; k < stall; k++) begin
            IMemAck = 1'($urandom);
            IMemData = $urandom;
            tick();
            check("stall_instr", Instr, data);
            check("stall_ipc", InstrPC, m_pc);
            check("stall_valid", InstrValid, 1'b1);
            check("stall_req", IMemReq, 1'b0);
        end
        IMemAck = 1'b0;
        Stall = 1'b0;
        Branch = br;
        Uncondbranch = ub;
        Zero = z;
        BusImm = imm;
        tick();
        Branch = 1'($urandom);
        Uncondbranch = 1'($urandom);
        Zero = 1'($urandom);
        BusImm = {$urandom, $urandom};
        if (ub || (br && z)) m_pc = m_pc + imm * 64'd4;
        else                 m_pc = m_pc + 64'd4;
        check("next_valid", InstrValid, 1'b0);
        check("next_req", IMemReq, 1'b1);
        check("next_addr", IMemAddr, m_pc);
        check("next_cur", CurrentPC, m_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] imm;
        logic signed [11:0] simm;

        #1;
        do_reset(64'h1000, 1'b0);
        check("dir_first_addr", IMemAddr, 64'h1000);
        do_instr(3, 32'h8B020020, 0, 1'b0, 1'b0, 1'b0, 64'd0);
        check("dir_seq", IMemAddr, 64'h1004);
        do_instr(0, $urandom, 0, 1'b0, 1'b0, 1'b0, 64'd0);
        check("dir_seq2", IMemAddr, 64'h1008);
        do_instr(1, $urandom, 1, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        check("dir_uncond_back", IMemAddr, 64'h1000);
        do_instr(0, $urandom, 0, 1'b0, 1'b0, 1'b0, 64'd0);
        do_instr(0, $urandom, 0, 1'b0, 1'b0, 1'b0, 64'd0);
        do_instr(0, $urandom, 0, 1'b1, 1'b0, 1'b0, 64'd3);
        check("dir_br_nottaken", IMemAddr, 64'h100C);
        do_instr(0, $urandom, 0, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        check("dir_back_1008", IMemAddr, 64'h1008);
        do_instr(2, $urandom, 0, 1'b1, 1'b0, 1'b1, 64'd3);
        check("dir_br_taken", IMemAddr, 64'h1014);

        for (int n = 0; n < 30; n++) begin
            simm = 12'($urandom);
            imm = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : {{52{simm[11]}}, simm};
            do_instr($urandom_range(0, 6), $urandom, $urandom_range(0, 3),
                     1'($urandom), 1'($urandom), 1'($urandom), imm);
        end

        // Reset while a request is pending, with an ack straggling past release.
        do_reset(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        check("restart_addr", IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
        do_instr(2, $urandom, 5, 1'b0, 1'b0, 1'b0, 64'd0);
        check("wrap_zero", IMemAddr, 64'd0);

        for (int i = 0; i < 16; i++) begin
            check("to_req", IMemReq, 1'b1);
            check("to_noerr", FetchErr, 1'b0);
            IMemAck = 1'b0;
            tick();
        end
        check("to_err", FetchErr, 1'b1);
        check("to_err_req", IMemReq, 1'b0);
        check("to_err_valid", InstrValid, 1'b0);
        for (int i = 0; i < 3; i++) begin
            IMemAck = 1'b1;
            tick();
            check("err_sticky", FetchErr, 1'b1);
            check("err_noreq", IMemReq, 1'b0);
            check("err_novalid", InstrValid, 1'b0);
        end
        IMemAck = 1'b0;

        do_reset(64'h2000, 1'b0);
        check("err_cleared", FetchErr, 1'b0);
        do_instr(15, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1'b0, 64'd0);
        check("edge_ack_err", FetchErr, 1'b0);
        check("edge_ack_addr", IMemAddr, 64'h2004);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
